// File: rtl/module_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pkg_wb
//   Shared types and constants for the writeback arbiter slice.
//   - REG_ADDR_W : register-file address width
//   - XLEN       : datapath width
//   - wb_entry_t : one pending register-file write (destination + data)
// ---------------------------------------------------------------------------
package pkg_wb;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage : pkg_wb

// File: rtl/module_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// module_wb_fifo
//   DEPTH-entry synchronous FIFO holding load results that wait for a
//   register-file write slot.  Head entry is visible on head_o whenever
//   empty_o is low; a pop consumes it at the next rising edge.
//
//   Ports:
//     clk_i    : clock, all state on the rising edge
//     rst_i    : synchronous active-high reset (pointers and count only)
//     push_i   : write din_i into the tail (ignored when full)
//     din_i    : entry to push
//     pop_i    : discard the head entry (ignored when empty)
//     head_o   : current head entry
//     full_o   : count == DEPTH
//     empty_o  : count == 0
//     count_o  : number of buffered entries
//
//   DEPTH must be a power of two so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module module_wb_fifo
  import pkg_wb::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  wb_entry_t        din_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [CNT_W-1:0] count_p1;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_p1 == DEPTH_CNT);
  assign empty_o = (count_p1 == '0);
  assign count_o = count_p1;
  assign head_o  = mem[rd_ptr_p1];

  // Guard against misuse so the count can never over- or underflow.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  // ---- control state: pointers and occupancy ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push_ok) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
      if (pop_ok)  rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_p1 <= count_p1 + 1'b1;
        2'b01:   count_p1 <= count_p1 - 1'b1;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // ---- storage: data only, never reset ----
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) begin
      mem[wr_ptr_p1] <= din_i;
    end
  end

endmodule : module_wb_fifo

// File: rtl/module_wb_arbiter.sv
// ---------------------------------------------------------------------------
// module_wb_arbiter
//   Owns the register-file write port (we3/a3/wd3) and merges two sources:
//     - ALU results: single cycle, no backpressure, normally highest priority
//     - load results: valid/ready handshake, buffered in module_wb_fifo
//   At most one register-file write per cycle.  A buffered load that keeps
//   losing to the ALU for STARVE_MAX cycles gets a forced slot: alu_stall_o
//   is raised for one cycle and the FIFO head is written in that cycle.
//
//   Ports:
//     clk_i, rst_i       : clock, synchronous active-high reset
//     alu_valid_i/rd/data: ALU result this cycle
//     alu_stall_o        : upstream must keep alu_valid_i low this cycle
//     ld_valid_i/rd/data : load result offered
//     ld_ready_o         : FIFO has room for a load result
//     we3_o/a3_o/wd3_o   : registered register-file write port
//     busy_o             : at least one load is buffered
//     perf_defer_o       : (WB_PERF_EN only) cycles a buffered load lost to
//                          the ALU, 32-bit wrapping
//
//   Build option: define WB_PERF_EN to add the perf_defer_o counter.
//   Writes to x0 take their slot (and pop the FIFO) but leave we3_o low.
// ---------------------------------------------------------------------------
module module_wb_arbiter
  import pkg_wb::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  output logic                  alu_stall_o,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [XLEN-1:0]       ld_data_i,
  output logic                  we3_o,
  output logic [REG_ADDR_W-1:0] a3_o,
  output logic [XLEN-1:0]       wd3_o,
`ifdef WB_PERF_EN
  output logic [31:0]           perf_defer_o,
`endif
  output logic                  busy_o
);

  localparam int          CNT_W      = $clog2(DEPTH) + 1;
  localparam int          STARVE_W   = 8;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // FIFO interface
  wb_entry_t        ld_entry;
  wb_entry_t        fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Arbitration
  logic                grant_alu;
  logic                grant_ld;
  logic                defer;
  wb_entry_t           wr_entry;
  logic [STARVE_W-1:0] starve_next;
  logic                stall_next;

  // Registered state
  logic                  stall_p1;
  logic [STARVE_W-1:0]   starve_cnt_p1;
  logic                  we3_p1;
  logic [REG_ADDR_W-1:0] a3_p1;
  logic [XLEN-1:0]       wd3_p1;

  assign ld_entry.rd   = ld_rd_i;
  assign ld_entry.data = ld_data_i;

  assign ld_ready_o = !fifo_full;
  assign fifo_push  = ld_valid_i && ld_ready_o && !rst_i;
  assign fifo_pop   = grant_ld;
  assign busy_o     = (fifo_count != '0);

  module_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .din_i   (ld_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Grant decision.  Emptiness comes from the registered count, so a load
  // pushed this cycle can only be popped from the next cycle on.  During a
  // forced slot the FIFO wins even if the ALU (illegally) offers a result;
  // that ALU result is dropped.
  always_comb begin
    grant_alu   = 1'b0;
    grant_ld    = 1'b0;
    wr_entry    = fifo_head;
    starve_next = starve_cnt_p1;

    if (stall_p1) begin
      grant_ld = !fifo_empty;
    end else if (alu_valid_i) begin
      grant_alu = 1'b1;
    end else begin
      grant_ld = !fifo_empty;
    end

    if (grant_alu) begin
      wr_entry.rd   = alu_rd_i;
      wr_entry.data = alu_data_i;
    end

    defer = grant_alu && !fifo_empty;

    if (fifo_empty || grant_ld) begin
      starve_next = '0;
    end else if (defer) begin
      starve_next = starve_cnt_p1 + 1'b1;
    end

    // Reaching the limit reserves the next cycle for the FIFO head.
    stall_next = defer && (starve_next == STARVE_LIM);
  end

  assign alu_stall_o = stall_p1;

  // ---- stage p1: registered write port and starvation control ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_p1      <= 1'b0;
      starve_cnt_p1 <= '0;
      we3_p1        <= 1'b0;
      a3_p1         <= '0;
      wd3_p1        <= '0;
    end else begin
      stall_p1      <= stall_next;
      starve_cnt_p1 <= starve_next;
      we3_p1        <= (grant_alu || grant_ld) && (wr_entry.rd != '0);
      if (grant_alu || grant_ld) begin
        a3_p1  <= wr_entry.rd;
        wd3_p1 <= wr_entry.data;
      end
    end
  end

  assign we3_o = we3_p1;
  assign a3_o  = a3_p1;
  assign wd3_o = wd3_p1;

`ifdef WB_PERF_EN
  logic [31:0] perf_defer_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_defer_p1 <= '0;
    end else if (defer) begin
      perf_defer_p1 <= perf_defer_p1 + 32'd1;
    end
  end

  assign perf_defer_o = perf_defer_p1;
`endif

endmodule : module_wb_arbiter

// File: tb/tb_module_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_module_wb_arbiter
//   Directed bench for module_wb_arbiter with DEPTH=4, STARVE_MAX=8.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so each tick() shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_module_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        busy;
`ifdef WB_PERF_EN
  logic [31:0] perf_defer;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int proto_errors = 0;

  always #5 clk = ~clk;

  module_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alu_valid_i  (alu_valid),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .alu_stall_o  (alu_stall),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_rd_i      (ld_rd),
    .ld_data_i    (ld_data),
    .we3_o        (we3),
    .a3_o         (a3),
    .wd3_o        (wd3),
`ifdef WB_PERF_EN
    .perf_defer_o (perf_defer),
`endif
    .busy_o       (busy)
  );

  // The bench must never offer an ALU result during a forced load slot.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      assert (!(alu_stall === 1'b1 && alu_valid === 1'b1))
      else begin
        proto_errors++;
        $display("FAIL proto_alu_during_stall: alu_valid=%0b alu_stall=%0b", alu_valid, alu_stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hCAFE0003;
    tick(); tick();
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL reset_we3: got %0b want 0", we3); end
    tests_run++; if (a3 !== 5'd0) begin tests_failed++; $display("FAIL reset_a3: got %0d want 0", a3); end
    tests_run++; if (wd3 !== 32'd0) begin tests_failed++; $display("FAIL reset_wd3: got %h want 0", wd3); end
    tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ld_ready: got %0b want 1", ld_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (alu_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b want 0", alu_stall); end
    rst = 1'b0; idle();
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_no_push_busy: got %0b want 0", busy); end
    tick();
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL reset_no_push_we3: got %0b want 0", we3); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    tests_run++; if (we3 !== 1'b1) begin tests_failed++; $display("FAIL alu_we3: got %0b want 1", we3); end
    tests_run++; if (a3 !== 5'd5) begin tests_failed++; $display("FAIL alu_a3: got %0d want 5", a3); end
    tests_run++; if (wd3 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL alu_wd3: got %h want deadbeef", wd3); end
    alu_valid = 1'b0;
    tick();
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_we3: got %0b want 0", we3); end
    tests_run++; if (a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL alu_idle_hold: got a3=%0d wd3=%h want 5/deadbeef", a3, wd3);
    end
  endtask

  task automatic test_load_only();
    tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL load_ready: got %0b want 1", ld_ready); end
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
    tick();
    ld_valid = 1'b0;
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL load_n1_we3: got %0b want 0", we3); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL load_n1_busy: got %0b want 1", busy); end
    tick();
    tests_run++; if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h12345678) begin
      tests_failed++; $display("FAIL load_n2_write: got we3=%0b a3=%0d wd3=%h want 1/7/12345678", we3, a3, wd3);
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL load_n2_busy: got %0b want 0", busy); end
    tick();
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL load_n3_we3: got %0b want 0", we3); end
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'h100 + 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'hF0000000 + 32'(i);
      tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_%0d: got %0b want 1", i, ld_ready); end
      tick();
      tests_run++; if (we3 !== 1'b1 || a3 !== 5'(1 + i)) begin
        tests_failed++; $display("FAIL full_alu_%0d: got we3=%0b a3=%0d want 1/%0d", i, we3, a3, 1 + i);
      end
    end
    ld_rd = 5'd24; ld_data = 32'hF0000004;
    tests_run++; if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL full_not_ready: got %0b want 0", ld_ready); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy: got %0b want 1", busy); end
    for (int j = 0; j < 2; j++) begin
      alu_rd = 5'(5 + j); alu_data = 32'h200 + 32'(j);
      tick();
      tests_run++; if (ld_ready !== 1'b0 || alu_stall !== 1'b0 || a3 !== 5'(5 + j)) begin
        tests_failed++; $display("FAIL full_hold_%0d: got ready=%0b stall=%0b a3=%0d want 0/0/%0d", j, ld_ready, alu_stall, a3, 5 + j);
      end
    end
    alu_valid = 1'b0;
    tick();
    tests_run++; if (we3 !== 1'b1 || a3 !== 5'd20 || wd3 !== 32'hF0000000) begin
      tests_failed++; $display("FAIL full_pop0: got we3=%0b a3=%0d wd3=%h want 1/20/f0000000", we3, a3, wd3);
    end
    tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_after_pop: got %0b want 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    tests_run++; if (a3 !== 5'd21) begin tests_failed++; $display("FAIL full_pop1: got a3=%0d want 21", a3); end
    tick();
    tests_run++; if (a3 !== 5'd22) begin tests_failed++; $display("FAIL full_pop2: got a3=%0d want 22", a3); end
    tick();
    tests_run++; if (a3 !== 5'd23) begin tests_failed++; $display("FAIL full_pop3: got a3=%0d want 23", a3); end
    tick();
    tests_run++; if (we3 !== 1'b1 || a3 !== 5'd24 || wd3 !== 32'hF0000004) begin
      tests_failed++; $display("FAIL full_pop_fifth: got we3=%0b a3=%0d wd3=%h want 1/24/f0000004", we3, a3, wd3);
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got busy=%0b want 0", busy); end
    tick();
  endtask

  task automatic starve_round(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b0; ld_valid = 1'b1; ld_rd = rd; ld_data = data;
    tick();
    ld_valid = 1'b0;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'(i);
      tick();
      tests_run++; if (alu_stall !== (i == STARVE_MAX) || we3 !== 1'b1 || a3 !== 5'(i)) begin
        tests_failed++; $display("FAIL starve_cyc_%0d_rd%0d: got stall=%0b we3=%0b a3=%0d want %0b/1/%0d", i, rd, alu_stall, we3, a3, i == STARVE_MAX, i);
      end
    end
    alu_valid = 1'b0;
    tick();
    tests_run++; if (we3 !== 1'b1 || a3 !== rd || wd3 !== data) begin
      tests_failed++; $display("FAIL starve_forced_write_rd%0d: got we3=%0b a3=%0d wd3=%h want 1/%0d/%h", rd, we3, a3, wd3, rd, data);
    end
    tests_run++; if (alu_stall !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL starve_after_rd%0d: got stall=%0b busy=%0b want 0/0", rd, alu_stall, busy);
    end
  endtask

  task automatic test_starvation();
    starve_round(5'd9,  32'hA5A50009);
    starve_round(5'd10, 32'hA5A5000A);
    tick();
  endtask

  task automatic test_x0_push_pop();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0000C00C;
    tick();
    alu_rd = 5'd2; alu_data = 32'h2;
    ld_rd = 5'd13; ld_data = 32'h0000D00D;
    tick();
    alu_valid = 1'b0;
    ld_rd = 5'd0; ld_data = 32'h0000BAD0;
    tick();
    ld_valid = 1'b0;
    tests_run++; if (we3 !== 1'b1 || a3 !== 5'd12 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL x0_pushpop: got we3=%0b a3=%0d busy=%0b want 1/12/1", we3, a3, busy);
    end
    tick();
    tests_run++; if (we3 !== 1'b1 || a3 !== 5'd13 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL x0_pop13: got we3=%0b a3=%0d busy=%0b want 1/13/1", we3, a3, busy);
    end
    tick();
    tests_run++; if (we3 !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL x0_pop_zero: got we3=%0b busy=%0b want 0/0", we3, busy);
    end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL x0_alu: got we3=%0b want 0", we3); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3;
    ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'hE;
    tick(); tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    tick();
    tests_run++; if (we3 !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset: got we3=%0b busy=%0b ready=%0b want 0/0/1", we3, busy, ld_ready);
    end
    rst = 1'b0; idle();
    tick();
    tests_run++; if (we3 !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_discard1: got we3=%0b busy=%0b want 0/0", we3, busy);
    end
    tick();
    tests_run++; if (we3 !== 1'b0) begin tests_failed++; $display("FAIL mid_discard2: got we3=%0b want 0", we3); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load_only();
    test_full_fifo();
    test_starvation();
    test_x0_push_pop();
    test_reset_mid();
    tests_failed += proto_errors;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_module_wb_arbiter
